// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Holds the FSM state type, the "no failing row" marker and the settle-counter width helper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample,
    StDone
  } state_e;

  localparam int unsigned MAX_INPUTS = 6;

  // Sliced down to N_INPUTS bits by users; all-ones means every row matched.
  localparam logic [MAX_INPUTS-1:0] NO_FAIL = '1;

  // Settle counter only needs to reach SETTLE_CYCLES-1.
  function automatic int unsigned settle_cnt_width(input int unsigned settle_cycles);
    return (settle_cycles < 2) ? 1 : $clog2(settle_cycles);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host-side control/result bundle of the truth-table sweeper.
// The host drives start/abort/expected; the sweeper returns status and the measured table.
interface truth_table_sweeper_if #(
  parameter int unsigned N_INPUTS = 4
);
  localparam int unsigned TT_W = 2**N_INPUTS;

  logic                start;
  logic                abort;
  logic [TT_W-1:0]     expected;
  logic                busy;
  logic                done;
  logic [TT_W-1:0]     table_out;
  logic                match;
  logic [N_INPUTS-1:0] first_fail;

  modport master (
    output start, abort, expected,
    input  busy, done, table_out, match, first_fail
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, table_out, match, first_fail
  );

endinterface

// File: rtl/tt_first_fail_enc.sv
// Priority encoder over a truth-table difference vector.
// Reports the lowest set index; idx is all-ones and found is low when nothing differs.
module tt_first_fail_enc #(
  parameter  int unsigned N_INPUTS = 4,
  localparam int unsigned TT_W     = 2**N_INPUTS
) (
  input  logic [TT_W-1:0]     diff,
  output logic [N_INPUTS-1:0] idx,
  output logic                found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '1;
    found = 1'b0;
    for (int i = int'(TT_W) - 1; i >= 0; i--) begin
      if (diff[i]) begin
        idx   = i[N_INPUTS-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector into a combinational netlist, samples its output after a settle
// time, and compares the measured truth table against an expected table latched at start.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter  int unsigned N_INPUTS      = 4,
  parameter  int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned TT_W          = 2**N_INPUTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave host,
  output logic [N_INPUTS-1:0]  dut_in,
  input  logic                 dut_out
);

  localparam int unsigned         CntW     = settle_cnt_width(SETTLE_CYCLES);
  localparam int unsigned         RowW     = N_INPUTS + 1;
  localparam logic [CntW-1:0]     CntLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [RowW-1:0]     RowLast  = RowW'(TT_W - 1);
  localparam logic [N_INPUTS-1:0] NoFailN  = NO_FAIL[N_INPUTS-1:0];

  state_e              state_q;
  logic [RowW-1:0]     row_q;
  logic [CntW-1:0]     cnt_q;
  logic [N_INPUTS-1:0] dut_in_q;
  logic                busy_q;
  logic                done_q;
  logic [TT_W-1:0]     table_q;
  logic [TT_W-1:0]     exp_q;
  logic                match_q;
  logic [N_INPUTS-1:0] first_fail_q;

  logic [TT_W-1:0]     table_nxt;
  logic [RowW-1:0]     row_inc;
  logic [N_INPUTS-1:0] ff_idx;
  logic                ff_found;

  // Table as it will stand after the current SAMPLE, so the verdict can be
  // registered on the same edge as the final row.
  always_comb begin
    table_nxt = table_q;
    table_nxt[row_q[N_INPUTS-1:0]] = dut_out;
  end

  assign row_inc = row_q + RowW'(1);

  tt_first_fail_enc #(
    .N_INPUTS (N_INPUTS)
  ) u_first_fail_enc (
    .diff  (table_nxt ^ exp_q),
    .idx   (ff_idx),
    .found (ff_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      cnt_q        <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      table_q      <= '0;
      exp_q        <= '0;
      match_q      <= 1'b0;
      first_fail_q <= NoFailN;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (host.start) begin
            state_q  <= StApply;
            row_q    <= '0;
            cnt_q    <= '0;
            dut_in_q <= '0;
            table_q  <= '0;
            exp_q    <= host.expected;
            busy_q   <= 1'b1;
          end
        end

        StApply: begin
          if (host.abort) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            dut_in_q <= '0;
            match_q  <= 1'b0;
          end else if (cnt_q == CntLast) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StSample: begin
          // Abort wins over capturing this row.
          if (host.abort) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            dut_in_q <= '0;
            match_q  <= 1'b0;
          end else begin
            table_q <= table_nxt;
            if (row_q == RowLast) begin
              state_q      <= StDone;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              match_q      <= ~ff_found;
              first_fail_q <= ff_found ? ff_idx : NoFailN;
            end else begin
              state_q  <= StApply;
              row_q    <= row_inc;
              dut_in_q <= row_inc[N_INPUTS-1:0];
              cnt_q    <= '0;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dut_in          = dut_in_q;
  assign host.busy       = busy_q;
  assign host.done       = done_q;
  assign host.table_out  = table_q;
  assign host.match      = match_q;
  assign host.first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with the default settle time and
// selectable netlist models, one with a single settle cycle.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  truth_table_sweeper_if #(.N_INPUTS(4)) if_a ();
  truth_table_sweeper_if #(.N_INPUTS(4)) if_b ();

  logic [3:0]  dut_in_a, dut_in_b;
  logic        dut_out_a, dut_out_b;
  logic [1:0]  mode_a;
  logic [15:0] hex_tt = 16'h22C6;
  logic [3:0]  hist1, hist2;

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(2)) u_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (if_a),
    .dut_in  (dut_in_a),
    .dut_out (dut_out_a)
  );

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (if_b),
    .dut_in  (dut_in_b),
    .dut_out (dut_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input history: the glitchy model is wrong until the vector has been stable two cycles.
  always @(posedge clk) begin
    hist1 <= dut_in_a;
    hist2 <= hist1;
  end

  always_comb begin
    dut_out_a = 1'b0;
    case (mode_a)
      2'd0:    dut_out_a = &dut_in_a;
      2'd1:    dut_out_a = hex_tt[dut_in_a];
      default: dut_out_a = (dut_in_a == hist1 && dut_in_a == hist2) ? hex_tt[dut_in_a]
                                                                    : ~hex_tt[dut_in_a];
    endcase
  end

  assign dut_out_b = dut_in_b[0];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic sweep_a(input logic [15:0] exp, output int done_edge);
    done_edge = -1;
    repeat (2) @(negedge clk);
    if_a.start    = 1'b1;
    if_a.expected = exp;
    @(posedge clk); #1;
    if_a.start    = 1'b0;
    if_a.expected = ~exp;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (if_a.done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (dut_in_a !== 4'h0) begin n_fail++;
      $display("FAIL reset_dut_in: got %h want 0", dut_in_a); end
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b want 0", if_a.busy); end
    n_checks++; if (if_a.done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %b want 0", if_a.done); end
    n_checks++; if (if_a.table_out !== 16'h0000) begin n_fail++;
      $display("FAIL reset_table: got %h want 0000", if_a.table_out); end
    n_checks++; if (if_a.match !== 1'b0) begin n_fail++;
      $display("FAIL reset_match: got %b want 0", if_a.match); end
    n_checks++; if (if_a.first_fail !== 4'hF) begin n_fail++;
      $display("FAIL reset_first_fail: got %h want f", if_a.first_fail); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_and_gate;
    int de;
    mode_a = 2'd0;
    sweep_a(16'h8000, de);
    n_checks++; if (de !== 48) begin n_fail++;
      $display("FAIL and_done_edge: got %0d want 48", de); end
    n_checks++; if (if_a.table_out !== 16'h8000) begin n_fail++;
      $display("FAIL and_table: got %h want 8000", if_a.table_out); end
    n_checks++; if (if_a.match !== 1'b1) begin n_fail++;
      $display("FAIL and_match: got %b want 1", if_a.match); end
    n_checks++; if (if_a.first_fail !== 4'hF) begin n_fail++;
      $display("FAIL and_first_fail: got %h want f", if_a.first_fail); end
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++;
      $display("FAIL and_busy_at_done: got %b want 0", if_a.busy); end
    @(posedge clk); #1;
    n_checks++; if (if_a.done !== 1'b0) begin n_fail++;
      $display("FAIL and_done_width: got %b want 0", if_a.done); end
    n_checks++; if (dut_in_a !== 4'hF) begin n_fail++;
      $display("FAIL and_dut_in_hold: got %h want f", dut_in_a); end
    n_checks++; if (if_a.match !== 1'b1) begin n_fail++;
      $display("FAIL and_match_held: got %b want 1", if_a.match); end
    sweep_a(16'h8001, de);
    n_checks++; if (if_a.match !== 1'b0) begin n_fail++;
      $display("FAIL and_bad_match: got %b want 0", if_a.match); end
    n_checks++; if (if_a.first_fail !== 4'h0) begin n_fail++;
      $display("FAIL and_bad_first_fail: got %h want 0", if_a.first_fail); end
  endtask

  task automatic test_hex;
    int de;
    mode_a = 2'd1;
    sweep_a(16'h22C6, de);
    n_checks++; if (de !== 48) begin n_fail++;
      $display("FAIL hex_done_edge: got %0d want 48", de); end
    n_checks++; if (if_a.table_out !== 16'h22C6) begin n_fail++;
      $display("FAIL hex_table: got %h want 22c6", if_a.table_out); end
    n_checks++; if (if_a.match !== 1'b1) begin n_fail++;
      $display("FAIL hex_match: got %b want 1", if_a.match); end
    n_checks++; if (if_a.first_fail !== 4'hF) begin n_fail++;
      $display("FAIL hex_first_fail: got %h want f", if_a.first_fail); end
    sweep_a(16'h22C4, de);
    n_checks++; if (if_a.table_out !== 16'h22C6) begin n_fail++;
      $display("FAIL hex2_table: got %h want 22c6", if_a.table_out); end
    n_checks++; if (if_a.match !== 1'b0) begin n_fail++;
      $display("FAIL hex2_match: got %b want 0", if_a.match); end
    n_checks++; if (if_a.first_fail !== 4'h1) begin n_fail++;
      $display("FAIL hex2_first_fail: got %h want 1", if_a.first_fail); end
  endtask

  task automatic test_glitch;
    int de;
    mode_a = 2'd2;
    sweep_a(16'h22C6, de);
    n_checks++; if (de !== 48) begin n_fail++;
      $display("FAIL glitch_done_edge: got %0d want 48", de); end
    n_checks++; if (if_a.table_out !== 16'h22C6) begin n_fail++;
      $display("FAIL glitch_table: got %h want 22c6", if_a.table_out); end
    n_checks++; if (if_a.match !== 1'b1) begin n_fail++;
      $display("FAIL glitch_match: got %b want 1", if_a.match); end
  endtask

  task automatic test_settle1;
    int de     = -1;
    int pulses = 0;
    @(negedge clk);
    if_b.start    = 1'b1;
    if_b.expected = 16'hAAAA;
    @(posedge clk); #1;
    if_b.start = 1'b0;
    n_checks++; if (if_b.busy !== 1'b1 || dut_in_b !== 4'h0) begin n_fail++;
      $display("FAIL s1_accept: got busy=%b dut_in=%h want busy=1 dut_in=0", if_b.busy, dut_in_b);
    end
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e <= 31) begin
        n_checks++; if (dut_in_b !== 4'(e / 2)) begin n_fail++;
          $display("FAIL s1_step_e%0d: got %h want %h", e, dut_in_b, 4'(e / 2)); end
      end
      if (if_b.done) begin
        pulses++;
        if (de < 0) de = e;
      end
    end
    n_checks++; if (de !== 32) begin n_fail++;
      $display("FAIL s1_done_edge: got %0d want 32", de); end
    n_checks++; if (pulses !== 1) begin n_fail++;
      $display("FAIL s1_done_pulses: got %0d want 1", pulses); end
    n_checks++; if (if_b.table_out !== 16'hAAAA) begin n_fail++;
      $display("FAIL s1_table: got %h want aaaa", if_b.table_out); end
    n_checks++; if (if_b.match !== 1'b1) begin n_fail++;
      $display("FAIL s1_match: got %b want 1", if_b.match); end
    n_checks++; if (dut_in_b !== 4'hF) begin n_fail++;
      $display("FAIL s1_dut_in_hold: got %h want f", dut_in_b); end
  endtask

  // Abort sampled at the given edge: 20 lands in APPLY of row 6, 21 in its SAMPLE cycle.
  task automatic abort_at(input int abort_edge);
    int pulses = 0;
    mode_a = 2'd1;
    repeat (2) @(negedge clk);
    if_a.start    = 1'b1;
    if_a.abort    = 1'b1;
    if_a.expected = 16'h22C6;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    n_checks++; if (if_a.busy !== 1'b1) begin n_fail++;
      $display("FAIL abort%0d_start_wins: got busy=%b want 1", abort_edge, if_a.busy); end
    for (int e = 1; e < abort_edge; e++) begin
      @(posedge clk); #1;
      if (if_a.done) pulses++;
    end
    if_a.abort = 1'b1;
    @(posedge clk); #1;
    if_a.abort = 1'b0;
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++;
      $display("FAIL abort%0d_busy: got %b want 0", abort_edge, if_a.busy); end
    n_checks++; if (dut_in_a !== 4'h0) begin n_fail++;
      $display("FAIL abort%0d_dut_in: got %h want 0", abort_edge, dut_in_a); end
    n_checks++; if (if_a.table_out !== 16'h0006) begin n_fail++;
      $display("FAIL abort%0d_table: got %h want 0006", abort_edge, if_a.table_out); end
    n_checks++; if (if_a.match !== 1'b0) begin n_fail++;
      $display("FAIL abort%0d_match: got %b want 0", abort_edge, if_a.match); end
    for (int e = 0; e < 60; e++) begin
      if (if_a.done) pulses++;
      @(posedge clk); #1;
    end
    n_checks++; if (pulses !== 0) begin n_fail++;
      $display("FAIL abort%0d_no_done: got %0d pulses want 0", abort_edge, pulses); end
  endtask

  task automatic test_abort;
    abort_at(20);
    abort_at(21);
  endtask

  task automatic test_back_to_back;
    int de     = -1;
    int pulses = 0;
    mode_a = 2'd0;
    repeat (2) @(negedge clk);
    if_a.start    = 1'b1;
    if_a.expected = 16'h8000;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    for (int e = 1; e <= 150; e++) begin
      @(posedge clk); #1;
      if (if_a.done) begin
        pulses++;
        if (de < 0) de = e;
      end
      if (e == 10 || e == 48) if_a.start = 1'b1;
      if (e == 11 || e == 49) if_a.start = 1'b0;
    end
    n_checks++; if (de !== 48) begin n_fail++;
      $display("FAIL b2b_done_edge: got %0d want 48", de); end
    n_checks++; if (pulses !== 1) begin n_fail++;
      $display("FAIL b2b_done_pulses: got %0d want 1", pulses); end
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_busy_after: got %b want 0", if_a.busy); end
    n_checks++; if (if_a.match !== 1'b1) begin n_fail++;
      $display("FAIL b2b_match: got %b want 1", if_a.match); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    mode_a = 2'd1;
    repeat (2) @(negedge clk);
    if_a.start    = 1'b1;
    if_a.expected = 16'h22C6;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_busy_done: got %b%b want 00", if_a.busy, if_a.done); end
    n_checks++; if (dut_in_a !== 4'h0) begin n_fail++;
      $display("FAIL rstmid_dut_in: got %h want 0", dut_in_a); end
    n_checks++; if (if_a.table_out !== 16'h0000) begin n_fail++;
      $display("FAIL rstmid_table: got %h want 0000", if_a.table_out); end
    n_checks++; if (if_a.match !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_match: got %b want 0", if_a.match); end
    n_checks++; if (if_a.first_fail !== 4'hF) begin n_fail++;
      $display("FAIL rstmid_first_fail: got %h want f", if_a.first_fail); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (if_a.done) pulses++;
    end
    n_checks++; if (pulses !== 0 || if_a.busy !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_no_done: got pulses=%0d busy=%b want 0 0", pulses, if_a.busy); end
  endtask

  initial begin
    rst_n         = 1'b0;
    mode_a        = 2'd0;
    if_a.start    = 1'b0;
    if_a.abort    = 1'b0;
    if_a.expected = '0;
    if_b.start    = 1'b0;
    if_b.abort    = 1'b0;
    if_b.expected = '0;
    test_reset();
    test_and_gate();
    test_hex();
    test_glitch();
    test_settle1();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
